// File: rtl/second_level_encode_sched.sv
// Round-robin scheduler sharing one RS(12,8) GF(16) parity encoder between NUM_REQ requesters.
// Two-stage pipeline: S1 holds the granted message, S2 holds message + parity + requester id.
module second_level_encode_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic [15:0]           rsp_parity,
    output logic [CNT_W-1:0]      enc_count
);

    // GF(16) multiply, field polynomial x^4 + x + 1
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // Systematic RS parity, g(x) = (x+a)(x+a^2)(x+a^3)(x+a^4) = x^4 + D x^3 + C x^2 + 8 x + 7.
    // vp[0] is the highest-degree message symbol; pp[k] is the coefficient of x^(3-k).
    function automatic logic [15:0] rs_parity(input logic [31:0] msg);
        logic [3:0] r3, r2, r1, r0, fb;
        r3 = 4'h0;
        r2 = 4'h0;
        r1 = 4'h0;
        r0 = 4'h0;
        for (int k = 0; k < 8; k++) begin
            fb = msg[4*k +: 4] ^ r3;
            r3 = r2 ^ gf_mul(fb, 4'hD);
            r2 = r1 ^ gf_mul(fb, 4'hC);
            r1 = r0 ^ gf_mul(fb, 4'h8);
            r0 = gf_mul(fb, 4'h7);
        end
        return {r0, r1, r2, r3};
    endfunction

    logic              v1_q, v1_d;
    logic [ID_W-1:0]   id1_q, id1_d;
    logic [31:0]       msg1_q, msg1_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [15:0]       rsp_parity_q, rsp_parity_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              adv2;
    logic              s1_free;
    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    logic              grant_hs;
    logic [15:0]       enc_parity;
    int                cand;

    assign enc_parity = rs_parity(msg1_q);
    assign adv2       = v1_q & (~rsp_valid_q | rsp_ready);
    assign s1_free    = ~v1_q | adv2;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_q) + off) % NUM_REQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(cand);
            end
        end
    end

    // Gated by rst so the grant bus reads idle while reset is held.
    assign req_ready = (gnt_found && s1_free && !rst) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign grant_hs  = |req_ready;

    always_comb begin
        v1_d         = v1_q;
        id1_d        = id1_q;
        msg1_d       = msg1_q;
        last_d       = last_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_parity_d = rsp_parity_q;
        cnt_d        = cnt_q;

        if (grant_hs) begin
            v1_d   = 1'b1;
            id1_d  = gnt_idx;
            msg1_d = req_data[32*gnt_idx +: 32];
            last_d = gnt_idx;
        end else if (adv2) begin
            v1_d = 1'b0;
        end

        if (adv2) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = id1_q;
            rsp_data_d   = msg1_q;
            rsp_parity_d = enc_parity;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (rsp_valid_q && rsp_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q         <= 1'b0;
            id1_q        <= '0;
            msg1_q       <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_parity_q <= '0;
            cnt_q        <= '0;
        end else begin
            v1_q         <= v1_d;
            id1_q        <= id1_d;
            msg1_q       <= msg1_d;
            last_q       <= last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_parity_q <= rsp_parity_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_parity = rsp_parity_q;
    assign enc_count  = cnt_q;

endmodule
